// File: rtl/nn_seq_ctrl_if.sv
// Stream-strobe and micro-op handshake bundle shared by nn_seq_ctrl,
// the input pads and the NN datapath/register file.
interface nn_seq_ctrl_if #(
    parameter int AW = 4
);
    logic          in_valid_w1;
    logic          in_valid_w2;
    logic          in_valid_d;
    logic          in_valid_t;
    logic          w1_we;
    logic [AW-1:0] w1_addr;
    logic          w2_we;
    logic [AW-1:0] w2_addr;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic          t_we;
    logic          op_valid;
    logic [2:0]    op_code;
    logic [AW-1:0] op_idx;
    logic          op_done;
    logic          out_valid;
    logic          weights_ready;
    logic          overrun;

    modport master (
        input  in_valid_w1, in_valid_w2, in_valid_d, in_valid_t, op_done,
        output w1_we, w1_addr, w2_we, w2_addr, d_we, d_addr, t_we,
               op_valid, op_code, op_idx, out_valid, weights_ready, overrun
    );

    modport slave (
        output in_valid_w1, in_valid_w2, in_valid_d, in_valid_t, op_done,
        input  w1_we, w1_addr, w2_we, w2_addr, d_we, d_addr, t_we,
               op_valid, op_code, op_idx, out_valid, weights_ready, overrun
    );
endinterface

// File: rtl/nn_seq_ctrl.sv
// Sequencing controller for the NN training datapath: addresses the weight,
// data and target streams and issues the fixed forward/backward/update op sequence.
module nn_seq_ctrl #(
    parameter int N_IN  = 4,
    parameter int N_HID = 3,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    nn_seq_ctrl_if.master bus
);
    localparam int W1_WORDS = N_IN * N_HID;

    // Counters are one bit wider than the address so they can hold the "full" value.
    localparam logic [AW:0]   W1_FULL  = (AW+1)'(W1_WORDS);
    localparam logic [AW:0]   W2_FULL  = (AW+1)'(N_HID);
    localparam logic [AW:0]   D_FULL   = (AW+1)'(N_IN);
    localparam logic [AW-1:0] HID_LAST = AW'(N_HID - 1);
    localparam logic [AW-1:0] W1_LAST  = AW'(W1_WORDS - 1);

    typedef enum logic [2:0] {IDLE, WAIT_D, FWD_H, FWD_O, BWD, UPD_W2, UPD_W1} state_t;

    state_t        state, state_nx;
    logic          waiting, waiting_nx;
    logic [AW-1:0] idx, idx_nx, last_idx;
    logic [AW:0]   w1_cnt, w1_cnt_nx, w2_cnt, w2_cnt_nx, d_cnt, d_cnt_nx;
    logic [AW:0]   w1_base, w2_base;
    logic          t_flag, t_flag_nx;
    logic          ready, ready_nx;
    logic          overrun_q, overrun_nx;
    logic          reload, any_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            waiting   <= 1'b0;
            idx       <= '0;
            w1_cnt    <= '0;
            w2_cnt    <= '0;
            d_cnt     <= '0;
            t_flag    <= 1'b0;
            ready     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_nx;
            waiting   <= waiting_nx;
            idx       <= idx_nx;
            w1_cnt    <= w1_cnt_nx;
            w2_cnt    <= w2_cnt_nx;
            d_cnt     <= d_cnt_nx;
            t_flag    <= t_flag_nx;
            ready     <= ready_nx;
            overrun_q <= overrun_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        waiting_nx = waiting;
        idx_nx     = idx;
        w1_cnt_nx  = w1_cnt;
        w2_cnt_nx  = w2_cnt;
        d_cnt_nx   = d_cnt;
        t_flag_nx  = t_flag;
        ready_nx   = ready;
        overrun_nx = overrun_q;
        reload     = 1'b0;
        w1_base    = w1_cnt;
        w2_base    = w2_cnt;
        any_valid  = bus.in_valid_w1 | bus.in_valid_w2 | bus.in_valid_d | bus.in_valid_t;

        bus.w1_we         = 1'b0;
        bus.w1_addr       = w1_cnt[AW-1:0];
        bus.w2_we         = 1'b0;
        bus.w2_addr       = w2_cnt[AW-1:0];
        bus.d_we          = 1'b0;
        bus.d_addr        = d_cnt[AW-1:0];
        bus.t_we          = 1'b0;
        bus.op_valid      = 1'b0;
        bus.op_code       = 3'd0;
        bus.op_idx        = '0;
        bus.weights_ready = ready;
        bus.overrun       = overrun_q;
        // The network result is ready exactly when BWD idx 0 is being issued.
        bus.out_valid     = (state == BWD) && !waiting && (idx == '0);

        case (state)
            FWD_H, BWD, UPD_W2: last_idx = HID_LAST;
            UPD_W1:             last_idx = W1_LAST;
            default:            last_idx = '0;
        endcase

        if (state == IDLE || state == WAIT_D) begin
            // A weight word after a complete load starts a fresh load from address 0.
            reload = (state == WAIT_D) && (bus.in_valid_w1 || bus.in_valid_w2);
            if (reload) begin
                w1_base  = '0;
                w2_base  = '0;
                ready_nx = 1'b0;
                state_nx = IDLE;
            end
            bus.w1_addr = w1_base[AW-1:0];
            bus.w2_addr = w2_base[AW-1:0];
            w1_cnt_nx   = w1_base;
            w2_cnt_nx   = w2_base;
            if (bus.in_valid_w1 && w1_base != W1_FULL) begin
                bus.w1_we = 1'b1;
                w1_cnt_nx = w1_base + 1'b1;
            end
            if (bus.in_valid_w2 && w2_base != W2_FULL) begin
                bus.w2_we = 1'b1;
                w2_cnt_nx = w2_base + 1'b1;
            end

            if (state == IDLE) begin
                if (w1_cnt_nx == W1_FULL && w2_cnt_nx == W2_FULL) begin
                    ready_nx = 1'b1;
                    state_nx = WAIT_D;
                end
            end else if (!reload) begin
                if (bus.in_valid_d && d_cnt != D_FULL) begin
                    bus.d_we = 1'b1;
                    d_cnt_nx = d_cnt + 1'b1;
                end
                if (bus.in_valid_t) begin
                    bus.t_we  = 1'b1;
                    t_flag_nx = 1'b1;
                end
                if (d_cnt == D_FULL && t_flag) begin
                    state_nx   = FWD_H;
                    waiting_nx = 1'b0;
                    idx_nx     = '0;
                    d_cnt_nx   = '0;
                    t_flag_nx  = 1'b0;
                end
            end
        end else begin
            overrun_nx = overrun_q | any_valid;
            bus.op_idx = idx;
            case (state)
                FWD_H:   bus.op_code = 3'd1;
                FWD_O:   bus.op_code = 3'd2;
                BWD:     bus.op_code = 3'd3;
                UPD_W2:  bus.op_code = 3'd4;
                default: bus.op_code = 3'd5;
            endcase

            if (!waiting) begin
                bus.op_valid = 1'b1;
                waiting_nx   = 1'b1;
            end else if (bus.op_done) begin
                waiting_nx = 1'b0;
                if (idx != last_idx) begin
                    idx_nx = idx + 1'b1;
                end else begin
                    idx_nx = '0;
                    case (state)
                        FWD_H:   state_nx = FWD_O;
                        FWD_O:   state_nx = BWD;
                        BWD:     state_nx = UPD_W2;
                        UPD_W2:  state_nx = UPD_W1;
                        default: state_nx = WAIT_D;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_nn_seq_ctrl.sv
// Bench for nn_seq_ctrl: vector table for stream loading, scoreboarded op sequence,
// and hand-written sequences for overrun, reset and reload corners.
module tb_nn_seq_ctrl;
    localparam int N_IN  = 4;
    localparam int N_HID = 3;
    localparam int AW    = 4;
    localparam int N_W1  = N_IN * N_HID;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    nn_seq_ctrl_if #(.AW(AW)) bus ();

    nn_seq_ctrl #(.N_IN(N_IN), .N_HID(N_HID), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0]    code;
        logic [AW-1:0] idx;
        logic          outv;
    } op_t;

    typedef struct {
        logic          w1, w2, d, t;
        logic          w1_we, w2_we, d_we, t_we, rdy;
        logic [AW-1:0] w1_a, w2_a, d_a;
    } vec_t;

    vec_t tbl [17];
    op_t  exp_q [$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   op_cnt = 0;
    int   ov_cnt = 0;
    int   cyc_n = 0;
    int   last_issue = -1;
    int   done_lat = 3;
    int   cd = 0;
    bit   spur_done = 1'b0;
    int   base_op, base_ov;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc_n);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.in_valid_w1 = v.w1;
        bus.in_valid_w2 = v.w2;
        bus.in_valid_d  = v.d;
        bus.in_valid_t  = v.t;
    endtask

    task automatic clearInputs();
        bus.in_valid_w1 = 1'b0;
        bus.in_valid_w2 = 1'b0;
        bus.in_valid_d  = 1'b0;
        bus.in_valid_t  = 1'b0;
    endtask

    task automatic runRows(input int lo, input int hi);
        for (int r = lo; r <= hi; r++) begin
            applyStimulus(tbl[r]);
            @(negedge clk);
            checkOutput($sformatf("row%0d_w1_we", r),   32'(bus.w1_we),         32'(tbl[r].w1_we));
            checkOutput($sformatf("row%0d_w1_addr", r), 32'(bus.w1_addr),       32'(tbl[r].w1_a));
            checkOutput($sformatf("row%0d_w2_we", r),   32'(bus.w2_we),         32'(tbl[r].w2_we));
            checkOutput($sformatf("row%0d_w2_addr", r), 32'(bus.w2_addr),       32'(tbl[r].w2_a));
            checkOutput($sformatf("row%0d_d_we", r),    32'(bus.d_we),          32'(tbl[r].d_we));
            checkOutput($sformatf("row%0d_d_addr", r),  32'(bus.d_addr),        32'(tbl[r].d_a));
            checkOutput($sformatf("row%0d_t_we", r),    32'(bus.t_we),          32'(tbl[r].t_we));
            checkOutput($sformatf("row%0d_ready", r),   32'(bus.weights_ready), 32'(tbl[r].rdy));
            cyc();
        end
        clearInputs();
    endtask

    // Expected op order for one full training step.
    task automatic pushOps();
        op_t e;
        last_issue = -1;
        for (int i = 0; i < N_HID; i++) begin
            e.code = 3'd1; e.idx = AW'(i); e.outv = 1'b0; exp_q.push_back(e);
        end
        e.code = 3'd2; e.idx = '0; e.outv = 1'b0; exp_q.push_back(e);
        for (int i = 0; i < N_HID; i++) begin
            e.code = 3'd3; e.idx = AW'(i); e.outv = (i == 0); exp_q.push_back(e);
        end
        for (int i = 0; i < N_HID; i++) begin
            e.code = 3'd4; e.idx = AW'(i); e.outv = 1'b0; exp_q.push_back(e);
        end
        for (int i = 0; i < N_W1; i++) begin
            e.code = 3'd5; e.idx = AW'(i); e.outv = 1'b0; exp_q.push_back(e);
        end
    endtask

    task automatic loadSample();
        pushOps();
        for (int i = 0; i < N_IN; i++) begin
            bus.in_valid_d = 1'b1;
            bus.in_valid_t = (i == 1);
            @(negedge clk);
            checkOutput("sample_d_we",   32'(bus.d_we),   1);
            checkOutput("sample_d_addr", 32'(bus.d_addr), i);
            checkOutput("sample_t_we",   32'(bus.t_we),   32'(i == 1));
            cyc();
        end
        clearInputs();
    endtask

    task automatic waitOpCount(input int target, input int budget);
        int n = 0;
        while (op_cnt < target && n < budget) begin
            cyc();
            n++;
        end
        checkOutput("wait_op_count", op_cnt, target);
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cyc();
            n++;
        end
        checkOutput("drain_pending_ops", exp_q.size(), 0);
        repeat (done_lat + 2) cyc();
    endtask

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Datapath model: answers each op_valid with op_done done_lat cycles later.
    initial begin
        bus.op_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.op_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) bus.op_done = 1'b1;
            end
            if (spur_done) begin
                bus.op_done = 1'b1;
                spur_done   = 1'b0;
            end
            @(negedge clk);
            if (rst_n && bus.op_valid) cd = done_lat;
        end
    end

    always @(negedge clk) begin : monitor
        op_t e;
        if (bus.op_valid) begin
            op_cnt++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_op", 32'(bus.op_valid), 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("op_code",   32'(bus.op_code),   32'(e.code));
                checkOutput("op_idx",    32'(bus.op_idx),    32'(e.idx));
                checkOutput("out_valid", 32'(bus.out_valid), 32'(e.outv));
                if (last_issue >= 0) checkOutput("op_gap", cyc_n - last_issue, done_lat + 1);
                last_issue = cyc_n;
            end
        end else if (bus.out_valid) begin
            checkOutput("stray_out_valid", 32'(bus.out_valid), 0);
        end
        if (bus.out_valid) ov_cnt++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 13; i++) begin
            tbl[i].w1    = (i < N_W1);
            tbl[i].w2    = (i < N_HID);
            tbl[i].d     = 1'b0;
            tbl[i].t     = 1'b0;
            tbl[i].w1_we = (i < N_W1);
            tbl[i].w1_a  = AW'(i);
            tbl[i].w2_we = (i < N_HID);
            tbl[i].w2_a  = AW'((i < N_HID) ? i : N_HID);
            tbl[i].d_we  = 1'b0;
            tbl[i].d_a   = '0;
            tbl[i].t_we  = 1'b0;
            tbl[i].rdy   = (i == N_W1);
        end
        for (int i = 13; i < 17; i++) begin
            tbl[i].w1    = 1'b0;
            tbl[i].w2    = 1'b0;
            tbl[i].d     = 1'b1;
            tbl[i].t     = (i == 14);
            tbl[i].w1_we = 1'b0;
            tbl[i].w1_a  = AW'(N_W1);
            tbl[i].w2_we = 1'b0;
            tbl[i].w2_a  = AW'(N_HID);
            tbl[i].d_we  = 1'b1;
            tbl[i].d_a   = AW'(i - 13);
            tbl[i].t_we  = (i == 14);
            tbl[i].rdy   = 1'b1;
        end

        rst_n = 1'b0;
        clearInputs();
        repeat (2) cyc();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_op_valid",  32'(bus.op_valid),      0);
        checkOutput("reset_op_code",   32'(bus.op_code),       0);
        checkOutput("reset_op_idx",    32'(bus.op_idx),        0);
        checkOutput("reset_ready",     32'(bus.weights_ready), 0);
        checkOutput("reset_overrun",   32'(bus.overrun),       0);
        checkOutput("reset_out_valid", 32'(bus.out_valid),     0);
        checkOutput("reset_w1_addr",   32'(bus.w1_addr),       0);
        cyc();

        $display("[TB] weight load and first training step, datapath latency 3");
        runRows(0, 12);
        base_op = op_cnt;
        base_ov = ov_cnt;
        pushOps();
        runRows(13, 16);
        waitDrain(300);
        checkOutput("step1_op_count",   op_cnt - base_op, 22);
        checkOutput("step1_out_valid",  ov_cnt - base_ov, 1);
        checkOutput("step1_ready_kept", 32'(bus.weights_ready), 1);

        $display("[TB] back-to-back ops, datapath latency 1, spurious done");
        done_lat = 1;
        base_op  = op_cnt;
        base_ov  = ov_cnt;
        loadSample();
        waitDrain(200);
        checkOutput("step2_op_count",  op_cnt - base_op, 22);
        checkOutput("step2_out_valid", ov_cnt - base_ov, 1);
        base_op   = op_cnt;
        spur_done = 1'b1;
        repeat (5) cyc();
        checkOutput("spurious_done_no_issue", op_cnt - base_op, 0);

        $display("[TB] overrun during BWD wait");
        done_lat = 3;
        base_op  = op_cnt;
        base_ov  = ov_cnt;
        checkOutput("overrun_before", 32'(bus.overrun), 0);
        loadSample();
        waitOpCount(base_op + 5, 100);
        bus.in_valid_d = 1'b1;
        @(negedge clk);
        checkOutput("overrun_d_we",     32'(bus.d_we),     0);
        checkOutput("overrun_op_valid", 32'(bus.op_valid), 0);
        checkOutput("overrun_code_bwd", 32'(bus.op_code),  3);
        cyc();
        bus.in_valid_d = 1'b0;
        @(negedge clk);
        checkOutput("overrun_set", 32'(bus.overrun), 1);
        cyc();
        waitDrain(300);
        checkOutput("step3_op_count",  op_cnt - base_op, 22);
        checkOutput("step3_out_valid", ov_cnt - base_ov, 1);
        checkOutput("overrun_sticky",  32'(bus.overrun), 1);

        $display("[TB] reset during UPD_W1 idx 5");
        base_op = op_cnt;
        loadSample();
        waitOpCount(base_op + 16, 200);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        exp_q.delete();
        last_issue = -1;
        @(negedge clk);
        checkOutput("midrst_op_valid",  32'(bus.op_valid),      0);
        checkOutput("midrst_op_code",   32'(bus.op_code),       0);
        checkOutput("midrst_op_idx",    32'(bus.op_idx),        0);
        checkOutput("midrst_ready",     32'(bus.weights_ready), 0);
        checkOutput("midrst_overrun",   32'(bus.overrun),       0);
        checkOutput("midrst_out_valid", 32'(bus.out_valid),     0);
        cyc();
        repeat (6) cyc();
        checkOutput("midrst_late_done_ignored", op_cnt - base_op, 16);

        for (int i = 0; i < N_IN; i++) begin
            bus.in_valid_d = 1'b1;
            bus.in_valid_t = 1'b1;
            @(negedge clk);
            checkOutput("noweights_d_we", 32'(bus.d_we), 0);
            checkOutput("noweights_t_we", 32'(bus.t_we), 0);
            cyc();
        end
        clearInputs();
        repeat (4) cyc();
        checkOutput("noweights_no_issue", op_cnt - base_op, 16);

        $display("[TB] reload weights, extra data, weight reload in WAIT_D");
        runRows(0, 12);
        for (int i = 0; i < 13; i++) begin
            bus.in_valid_d = 1'b1;
            @(negedge clk);
            checkOutput($sformatf("extra_d_we%0d", i), 32'(bus.d_we), 32'(i < N_IN));
            if (i < N_IN) checkOutput($sformatf("extra_d_addr%0d", i), 32'(bus.d_addr), i);
            cyc();
        end
        clearInputs();
        repeat (3) cyc();
        checkOutput("extra_no_issue", op_cnt - base_op, 16);
        bus.in_valid_w2 = 1'b1;
        @(negedge clk);
        checkOutput("reload_w2_we",    32'(bus.w2_we),         1);
        checkOutput("reload_w2_addr",  32'(bus.w2_addr),       0);
        checkOutput("reload_ready_hi", 32'(bus.weights_ready), 1);
        cyc();
        bus.in_valid_w2 = 1'b0;
        @(negedge clk);
        checkOutput("reload_ready_lo",  32'(bus.weights_ready), 0);
        checkOutput("reload_w2_next",   32'(bus.w2_addr),       1);
        checkOutput("reload_w1_clear",  32'(bus.w1_addr),       0);
        checkOutput("reload_no_overrun", 32'(bus.overrun),      0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/nn_seq_ctrl.md
Name: nn_seq_ctrl

Overview:
- Sequencing controller for the NN training datapath.
- Counts and addresses the incoming weight, data and target word streams.
- Issues a fixed sequence of micro-operations to the shared floating-point compute unit: hidden forward, output forward, backward, W2 update, W1 update.
- Generates out_valid. Sits between the input pads and the NN datapath/register file; the datapath itself holds no control state.

Parameters:
- N_IN, 4, input-layer width; data words per sample.
- N_HID, 3, hidden-layer width. W1 holds N_IN*N_HID words; W2 holds N_HID words.
- AW, 4, address/index width; must satisfy 2^AW >= N_IN*N_HID.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid_w1  in  1  weight1 word present this cycle.
- in_valid_w2  in  1  weight2 word present this cycle.
- in_valid_d  in  1  data_point word present this cycle.
- in_valid_t  in  1  target word present this cycle.
- w1_we  out  1  write strobe for W1 storage.
- w1_addr  out  AW  W1 write address.
- w2_we  out  1  write strobe for W2 storage.
- w2_addr  out  AW  W2 write address.
- d_we  out  1  write strobe for data storage.
- d_addr  out  AW  data write address.
- t_we  out  1  write strobe for target register.
- op_valid  out  1  one-cycle micro-op issue strobe.
- op_code  out  3  1=FWD_H, 2=FWD_O, 3=BWD, 4=UPD_W2, 5=UPD_W1; 0 when idle.
- op_idx  out  AW  neuron/weight index for the issued op.
- op_done  in  1  datapath completion pulse for the outstanding op.
- out_valid  out  1  one-cycle pulse: datapath output register holds the network result.
- weights_ready  out  1  high when W1 and W2 are fully loaded.
- overrun  out  1  sticky: input word arrived while busy.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE; all counters clear.
  - All outputs read 0 the following cycle: every strobe, op_code, op_idx, weights_ready, overrun.
  - Reset mid-operation aborts any outstanding op. A late op_done is then ignored.
- States: IDLE, WAIT_D, FWD_H, FWD_O, BWD, UPD_W2, UPD_W1. Each compute state has two sub-phases: ISSUE and WAIT.
- Weight load (IDLE and WAIT_D only):
  - w1_we = in_valid_w1 combinationally; w1_addr = w1_cnt. w1_cnt increments per accepted word and saturates at N_IN*N_HID.
  - w2 path is the same, saturating at N_HID.
  - W1 and W2 streams may overlap in any cycles.
  - Any weight word accepted in WAIT_D first clears weights_ready and both counters; that word writes address 0.
  - weights_ready rises the cycle after both counters reach full. IDLE then moves to WAIT_D.
- Sample load (WAIT_D only):
  - d_we = in_valid_d; d_addr = d_cnt, saturating at N_IN. Words beyond N_IN are not written.
  - t_we = in_valid_t; one target per sample; may coincide with any data cycle.
  - When d_cnt==N_IN and the target has been received, the next state is FWD_H (ISSUE). d_cnt and the target flag clear.
- Op sequencing:
  - ISSUE drives op_valid=1 for exactly one cycle with op_code/op_idx valid, then enters WAIT.
  - op_code/op_idx hold their value through WAIT.
  - In WAIT, op_done moves to the next op's ISSUE on the next cycle.
  - op_done outside WAIT, or in the ISSUE cycle itself, is ignored. Minimum datapath latency is 1 cycle.
  - Order: FWD_H idx 0..N_HID-1; FWD_O idx 0; BWD idx 0..N_HID-1; UPD_W2 idx 0..N_HID-1; UPD_W1 idx 0..N_IN*N_HID-1.
  - Default op count: 22 ops. After the last UPD_W1 op_done, the next state is WAIT_D. Weights are retained; weights_ready stays 1.
- out_valid: one-cycle pulse in the cycle after FWD_O's op_done. It coincides with the BWD idx 0 op_valid.
- Overrun:
  - Any in_valid_* while in a compute state sets overrun (sticky until reset).
  - The word is not written and counters are unchanged.
  - Weight words in IDLE/WAIT_D are never overrun.
- No timeout: WAIT holds indefinitely until op_done.

Test Plan:
- Load check: reset, then 12 consecutive in_valid_w1 plus 3 in_valid_w2 overlapping cycles 0-2 -> w1_addr 0..11 and w2_addr 0..2 strobed; weights_ready=1 one cycle after the 12th word; state WAIT_D.
- Full training step: 4 in_valid_d with in_valid_t on the 2nd; datapath returns op_done 3 cycles after each op_valid -> 22 op_valid pulses with the exact code/idx order above; out_valid exactly once, cycle after the FWD_O done; return to WAIT_D.
- Back-to-back and spurious done: op_done 1 cycle after each op_valid, plus an extra op_done while in WAIT_D -> next op issued every 2 cycles; spurious done causes no issue.
- Overrun: in_valid_d pulse during BWD WAIT -> overrun=1 and stays set; d_we=0; next sample still loads at d_addr 0..3.
- Reset mid-run: rst_n low for 1 cycle during UPD_W1 idx 5, then op_done arrives -> all outputs 0, weights_ready=0, no op issued; a new weight load is required.
- Weight reload and extra data: 13 data words in WAIT_D -> only addresses 0..3 written. A w2 word in WAIT_D -> weights_ready drops and w2_addr restarts at 0.
